// File: rtl/dso_pkg.sv
// Shared types and width helpers for the DSO channel correction stage.
package dso_pkg;

  typedef enum logic [1:0] {SAT_NONE, SAT_LO, SAT_HI} sat_e;

  function automatic int ch_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unity_gain(input int gw);
    return 1 << (gw - 1);
  endfunction

endpackage

// File: rtl/sat_clip.sv
// Clamps a signed value to the unsigned range [0, 2^OUT_W-1] and reports the clamp direction.
module sat_clip
  import dso_pkg::*;
#(
  parameter int IN_W  = 10,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic        [OUT_W-1:0] o_val,
  output sat_e                    o_sat
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  always_comb begin
    o_val = i_val[OUT_W-1:0];
    o_sat = SAT_NONE;
    if (i_val[IN_W-1]) begin
      o_val = '0;
      o_sat = SAT_LO;
    end else if (i_val > MAX_V) begin
      o_val = '1;
      o_sat = SAT_HI;
    end
  end

endmodule

// File: rtl/dso_chan_correct.sv
// Two-stage per-channel offset/gain correction with clamping and per-channel clamp counters.
module dso_chan_correct
  import dso_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NUM_CH = 3,
  parameter  int GAIN_W = 8,
  parameter  int CNT_W  = 16,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_raw,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DATA_W-1:0] cfg_off,
  input  logic [GAIN_W-1:0] cfg_gain,
  output logic              out_vld,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_smpl,
  output logic              out_sat,
  input  logic              cnt_clr,
  input  logic [CH_W-1:0]   cnt_ch,
  output logic [CNT_W-1:0]  cnt_q
);

  localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(unity_gain(GAIN_W));
  localparam logic [CH_W:0]     NUM_CH_L   = (CH_W+1)'(NUM_CH);

  logic [DATA_W-1:0] r_off  [NUM_CH];
  logic [GAIN_W-1:0] r_gain [NUM_CH];
  logic [CNT_W-1:0]  r_cnt  [NUM_CH];

  logic              r_s1_vld, r_s1_sat;
  logic [CH_W-1:0]   r_s1_ch;
  logic [DATA_W-1:0] r_s1_smpl;
  logic [GAIN_W-1:0] r_s1_gain;

  logic              r_out_vld, r_out_sat;
  logic [CH_W-1:0]   r_out_ch;
  logic [DATA_W-1:0] r_out_smpl;

  logic                            w_in_ok, w_cfg_ok, w_cnt_ok;
  logic [DATA_W-1:0]               w_off;
  logic signed [DATA_W+1:0]        w_s1_sum;
  logic [DATA_W-1:0]               w_s1_val, w_s2_val;
  sat_e                            w_s1_sat, w_s2_sat;
  logic [DATA_W+GAIN_W-1:0]        w_prod;
  logic signed [DATA_W+GAIN_W-1:0] w_quot;

  assign w_in_ok  = ({1'b0, in_ch}  < NUM_CH_L);
  assign w_cfg_ok = ({1'b0, cfg_ch} < NUM_CH_L);
  assign w_cnt_ok = ({1'b0, cnt_ch} < NUM_CH_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_off[i]  <= '0;
        r_gain[i] <= GAIN_UNITY;
      end
    end else if (cfg_we && w_cfg_ok) begin
      r_off[cfg_ch]  <= cfg_off;
      r_gain[cfg_ch] <= cfg_gain;
    end
  end

  // Stage 1: raw + signed offset, two guard bits cover both overflow directions
  assign w_off    = r_off[in_ch];
  assign w_s1_sum = $signed({2'b00, in_raw}) + $signed({{2{w_off[DATA_W-1]}}, w_off});

  sat_clip #(.IN_W(DATA_W+2), .OUT_W(DATA_W)) u_clip_s1 (
    .i_val (w_s1_sum),
    .o_val (w_s1_val),
    .o_sat (w_s1_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_ch   <= '0;
      r_s1_smpl <= '0;
      r_s1_gain <= '0;
      r_s1_sat  <= 1'b0;
    end else begin
      r_s1_vld <= in_vld && w_in_ok;
      if (in_vld && w_in_ok) begin
        r_s1_ch   <= in_ch;
        r_s1_smpl <= w_s1_val;
        r_s1_gain <= r_gain[in_ch];
        r_s1_sat  <= (w_s1_sat != SAT_NONE);
      end
    end
  end

  // Stage 2: fixed-point gain; the shifted product can never be negative
  assign w_prod = {{GAIN_W{1'b0}}, r_s1_smpl} * {{DATA_W{1'b0}}, r_s1_gain};
  assign w_quot = $signed(w_prod >> (GAIN_W-1));

  sat_clip #(.IN_W(DATA_W+GAIN_W), .OUT_W(DATA_W)) u_clip_s2 (
    .i_val (w_quot),
    .o_val (w_s2_val),
    .o_sat (w_s2_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_ch   <= '0;
      r_out_smpl <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      r_out_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_out_ch   <= r_s1_ch;
        r_out_smpl <= w_s2_val;
        r_out_sat  <= r_s1_sat || (w_s2_sat != SAT_NONE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else if (r_out_vld && r_out_sat && (r_cnt[r_out_ch] != '1)) begin
      r_cnt[r_out_ch] <= r_cnt[r_out_ch] + CNT_W'(1);
    end
  end

  assign cnt_q    = w_cnt_ok ? r_cnt[cnt_ch] : '0;
  assign out_vld  = r_out_vld;
  assign out_ch   = r_out_ch;
  assign out_smpl = r_out_smpl;
  assign out_sat  = r_out_sat;

endmodule

// File: tb/tb_dso_chan_correct.sv
// Self-checking bench: vector table plus hand sequences, scoreboard-checked outputs.
module tb_dso_chan_correct;
  import dso_pkg::*;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 3;
  localparam int GAIN_W = 8;
  localparam int CNT_W  = 4;
  localparam int CH_W   = ch_width(NUM_CH);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_vld = 1'b0;
  logic [CH_W-1:0]   in_ch = '0;
  logic [DATA_W-1:0] in_raw = '0;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DATA_W-1:0] cfg_off = '0;
  logic [GAIN_W-1:0] cfg_gain = '0;
  logic              out_vld;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_smpl;
  logic              out_sat;
  logic              cnt_clr = 1'b0;
  logic [CH_W-1:0]   cnt_ch = '0;
  logic [CNT_W-1:0]  cnt_q;

  dso_chan_correct #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .GAIN_W(GAIN_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_ch(in_ch), .in_raw(in_raw),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_off(cfg_off), .cfg_gain(cfg_gain),
    .out_vld(out_vld), .out_ch(out_ch), .out_smpl(out_smpl), .out_sat(out_sat),
    .cnt_clr(cnt_clr), .cnt_ch(cnt_ch), .cnt_q(cnt_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_off;
    logic [7:0] cfg_gain;
    logic       in_vld;
    logic [1:0] in_ch;
    logic [7:0] in_raw;
    logic [7:0] exp_smpl;
    logic       exp_sat;
  } vec_t;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] smpl;
    logic       sat;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  vec_t tbl[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (out_vld) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_vld: got ch=%0d smpl=0x%0h, expected no output", out_ch, out_smpl);
      end else begin
        m_e = sb.pop_front();
        check("out_ch", int'(out_ch), int'(m_e.ch));
        check("out_smpl", int'(out_smpl), int'(m_e.smpl));
        check("out_sat", int'(out_sat), int'(m_e.sat));
        check("latency", cyc - m_e.cyc, 2);
      end
    end
  end

  function automatic vec_t mk(input logic we, input logic [1:0] cch, input logic [7:0] off,
                              input logic [7:0] gain, input logic v, input logic [1:0] ch,
                              input logic [7:0] raw, input logic [7:0] exp_s, input logic exp_sat);
    vec_t r;
    r.cfg_we = we;   r.cfg_ch = cch; r.cfg_off = off; r.cfg_gain = gain;
    r.in_vld = v;    r.in_ch = ch;   r.in_raw = raw;
    r.exp_smpl = exp_s; r.exp_sat = exp_sat;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    @(posedge clk); #1;
    cfg_we = v.cfg_we; cfg_ch = v.cfg_ch; cfg_off = v.cfg_off; cfg_gain = v.cfg_gain;
    in_vld = v.in_vld; in_ch = v.in_ch;   in_raw = v.in_raw;
    if (v.in_vld && (int'(v.in_ch) < NUM_CH))
      sb.push_back('{v.in_ch, v.exp_smpl, v.exp_sat, cyc});
  endtask

  task automatic sample(input logic [1:0] ch, input logic [7:0] raw, input logic [7:0] e, input logic s);
    drive(mk(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, ch, raw, e, s));
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [7:0] off, input logic [7:0] gain);
    drive(mk(1'b1, ch, off, gain, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_vld = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    end
  endtask

  task automatic check_cnt(input logic [1:0] ch, input int req, input string name);
    cnt_ch = ch; #1;
    check(name, int'(cnt_q), req);
  endtask

  initial begin
    // reset defaults, low clamp, two-stage high clamp, config collision, interleave + dropped ch3
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h7F, 8'h7F, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'hFF, 0));
    tbl.push_back(mk(1, 1, 8'hF0, 8'h80, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h05, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h10, 0));
    tbl.push_back(mk(1, 2, 8'h10, 8'h80, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2, 8'hF8, 8'hFF, 1));
    tbl.push_back(mk(1, 2, 8'h00, 8'hC0, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2, 8'hC0, 8'hFF, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2, 8'h40, 8'h60, 0));
    tbl.push_back(mk(1, 0, 8'h04, 8'h80, 1, 0, 8'h10, 8'h10, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h14, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h24, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'h20, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2, 8'h40, 8'h60, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 3, 8'h55, 8'h00, 0));
    tbl.push_back(mk(1, 3, 8'h50, 8'h01, 0, 0, 8'h00, 8'h00, 0));

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_vld", int'(out_vld), 0);
    check("rst_out_smpl", int'(out_smpl), 0);
    check_cnt(2'd0, 0, "rst_cnt0");
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);
    idle(4);

    check_cnt(2'd0, 0, "cnt_ch0");
    check_cnt(2'd1, 1, "cnt_ch1");
    check_cnt(2'd2, 2, "cnt_ch2");
    check_cnt(2'd3, 0, "cnt_ch3_invalid");

    // counter saturation at 4 bits
    cfg(2'd0, 8'h7F, 8'h80);
    for (int i = 0; i < 20; i++) sample(2'd0, 8'hFF, 8'hFF, 1'b1);
    idle(4);
    check_cnt(2'd0, 15, "cnt_saturate");
    check("hold_out_smpl", int'(out_smpl), 8'hFF);

    // clear coincident with a clamped output wins
    sample(2'd0, 8'hFF, 8'hFF, 1'b1);
    @(posedge clk); #1; in_vld = 1'b0;
    @(posedge clk); #1; cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
    check_cnt(2'd0, 0, "cnt_clr_priority");
    check_cnt(2'd2, 0, "cnt_clr_all");
    sample(2'd0, 8'hFF, 8'hFF, 1'b1);
    idle(4);
    check_cnt(2'd0, 1, "cnt_after_clr");

    // reset with a sample mid-pipeline
    sample(2'd1, 8'h30, 8'h20, 1'b0);
    @(posedge clk); #1;
    in_vld = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_vld", int'(out_vld), 0);
    check("midrst_out_smpl", int'(out_smpl), 0);
    check_cnt(2'd0, 0, "midrst_cnt0");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);

    // coefficients back to offset 0, unity gain
    sample(2'd1, 8'h05, 8'h05, 1'b0);
    sample(2'd2, 8'h40, 8'h40, 1'b0);
    idle(1);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    idle(2);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dso_chan_correct.md
# dso_chan_correct

Multi-channel, pipelined sample-correction stage for the DSO acquisition path. It applies a per-channel signed offset and then a per-channel unsigned gain to each unsigned ADC sample, clamping the result to the sample range at each step. It counts clamp events per channel. It sits between the ADC capture logic and the trigger/sample RAM write path, and generalises the earlier single-channel, offset-only saturating adder.

## Interface
- `DATA_W`, 8, sample width (unsigned raw, signed offset, unsigned output)
- `NUM_CH`, 3, number of channels; `CH_W = max(1, $clog2(NUM_CH))`
- `GAIN_W`, 8, unsigned gain width, fixed point; `1 << (GAIN_W-1)` = unity
- `CNT_W`, 16, saturation event counter width

Ports:
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `in_vld` in 1: input sample valid
- `in_ch` in CH_W: channel of the input sample
- `in_raw` in DATA_W: unsigned raw sample
- `cfg_we` in 1: write offset and gain for `cfg_ch`
- `cfg_ch` in CH_W: configuration channel
- `cfg_off` in DATA_W: signed offset
- `cfg_gain` in GAIN_W: unsigned gain
- `out_vld` out 1: corrected sample valid
- `out_ch` out CH_W: channel of the output sample
- `out_smpl` out DATA_W: corrected sample
- `out_sat` out 1: the output sample was clamped in either stage
- `cnt_clr` in 1: synchronous clear of all counters
- `cnt_ch` in CH_W: counter read select
- `cnt_q` out CNT_W: counter of `cnt_ch`, combinational read

## Operation
- **Coefficient file:** one offset and one gain per channel.
  - Reset values: offset 0, gain unity.
  - A `cfg_we` write takes effect at the next clock edge.
  - Writes with `cfg_ch >= NUM_CH` are ignored.
- **Stage 1** (on `in_vld`), computed at width DATA_W+2 (signed):
  - `s = zext(in_raw) + sext(off[in_ch])`.
  - If `s < 0`: result 0, low clamp. If `s > 2^DATA_W-1`: result all-ones, high clamp. Otherwise result is `s`.
  - The channel's gain is captured here together with the sample, so the sample uses coefficients from a single configuration.
- **Stage 2**, computed at width DATA_W+GAIN_W:
  - `p = s1 * gain1`, then `q = p >> (GAIN_W-1)`.
  - If `q > 2^DATA_W-1`: result all-ones, high clamp.
  - `out_sat` = stage-1 clamp OR stage-2 clamp.
- **Invalid channel:** an input with `in_ch >= NUM_CH` is dropped. No `out_vld` is produced and no counter changes.
- **Counters:**
  - `sat_cnt[out_ch]` increments when `out_vld && out_sat`.
  - A counter saturates at all-ones and does not wrap.
  - `cnt_clr` has priority over a simultaneous increment; the counter goes to 0.
  - `cnt_q` is 0 when `cnt_ch >= NUM_CH`.
- **Flow control:** none. The block accepts one sample every cycle with no backpressure. Bubbles propagate as `out_vld` = 0.

## Timing
- Latency is 2 cycles: a sample with `in_vld` at edge N produces `out_vld` high after edge N+2.
- Full throughput: one sample per clock, any interleaving of channels.
- **Config write in the same cycle as a sample on the same channel:** the sample uses the old offset and gain. The next sample uses the new values.
- **Reset:** asserting `rst_n` low at any time, including mid-pipeline, immediately clears:
  - `out_vld`, `out_ch`, `out_smpl`, `out_sat` to 0;
  - all pipeline valids;
  - all counters to 0;
  - coefficients to offset 0, gain unity.
  
  In-flight samples are discarded.
- `out_ch`, `out_smpl` and `out_sat` hold their last value while `out_vld` = 0.

## Structure
- **Package `dso_pkg`:**
  - typedef `sat_e {SAT_NONE, SAT_LO, SAT_HI}`;
  - function computing CH_W;
  - unity-gain constant expression.
- **Sub-module `sat_clip`:** parameterised `IN_W`/`OUT_W`. Clamps a signed IN_W value to [0, 2^OUT_W-1] and reports `sat_e`. Instantiated once per stage.
- Coefficient file and counters are flop arrays indexed by channel; no RAM macro.

## Test plan
1. **Reset defaults:** after reset, stream raw 0x00, 0x7F, 0xFF on channel 0 → out 0x00, 0x7F, 0xFF at 2-cycle latency, `out_sat` = 0 on all three.
2. **Low clamp:** ch1 offset −16 (0xF0), gain 0x80; raw 0x05 → out 0x00, `out_sat` = 1; raw 0x20 → out 0x10, `out_sat` = 0. `sat_cnt[1]` = 1.
3. **High clamp in both stages:**
   - ch2 offset +0x10, raw 0xF8 → out 0xFF, `out_sat` = 1 (stage-1 clamp).
   - ch2 offset 0, gain 0xC0, raw 0xC0 → out 0xFF, `out_sat` = 1 (stage-2 clamp).
   - ch2 offset 0, gain 0xC0, raw 0x40 → out 0x60, `out_sat` = 0.
4. **Config collision:** in the same cycle, write ch0 offset +4 and input ch0 raw 0x10 → out 0x10. The next ch0 sample, raw 0x10 → out 0x14.
5. **Interleave and dropped channel:** back-to-back samples on ch0, ch1, ch2, ch3 (invalid) → three `out_vld` pulses in order with the correct `out_ch`; ch3 is dropped with no counter change.
6. **Counter limits and reset:**
   - CNT_W=4: 20 clamped samples on ch0 → `cnt_q` = 0xF.
   - `cnt_clr` together with a clamped output → counter = 0.
   - `rst_n` low while `out_vld` is pending → no `out_vld` after release.
